// File: rtl/mult_m2_stage.sv
// M2 of the three-stage multiplier: sums partial products, applies sign,
// and registers result, zero and overflow flags toward M3.
module mult_m2_stage #(
  parameter int WIDTH = 32,
  parameter int ADDR  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             regwrite_mult_in,
  input  logic [ADDR-1:0]  wreg_in,
  input  logic             is_signed_in,
  input  logic             neg_in,
  input  logic [WIDTH-1:0] pp_ll,
  input  logic [WIDTH-1:0] pp_lh,
  input  logic [WIDTH-1:0] pp_hl,
  input  logic [WIDTH-1:0] pp_hh,
  input  logic             stall,
  input  logic             flush,
  output logic             valid_out,
  output logic             regwrite_out,
  output logic [ADDR-1:0]  wreg_out,
  output logic [WIDTH-1:0] pre_m2result,
  output logic             pre_zero,
  output logic             pre_overflow
);

  localparam int W2   = 2 * WIDTH;
  localparam int HALF = WIDTH / 2;

  logic [WIDTH:0]   mid;
  logic [W2-1:0]    mag;
  logic [W2-1:0]    prod;
  logic [WIDTH:0]   top;
  logic             neg_eff;

  logic             valid_q, valid_d;
  logic             rw_q, rw_d;
  logic [ADDR-1:0]  wreg_q, wreg_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  // Middle sum keeps its carry bit before being shifted into place.
  assign mid = {1'b0, pp_lh} + {1'b0, pp_hl};

  assign mag = {pp_hh, {WIDTH{1'b0}}}
             + ({{(WIDTH-1){1'b0}}, mid} << HALF)
             + {{WIDTH{1'b0}}, pp_ll};

  assign neg_eff = is_signed_in & neg_in;
  assign prod    = neg_eff ? (~mag + 1'b1) : mag;
  assign top     = prod[W2-1:WIDTH-1];

  always_comb begin
    valid_d = valid_in;
    rw_d    = regwrite_mult_in & valid_in;
    wreg_d  = wreg_in;
    res_d   = prod[WIDTH-1:0];
    zero_d  = (prod[WIDTH-1:0] == '0);
    if (is_signed_in)
      ovf_d = ~((&top) | ~(|top));
    else
      ovf_d = |mag[W2-1:WIDTH];
    if (flush) begin
      valid_d = 1'b0;
      rw_d    = 1'b0;
      zero_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      wreg_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!stall) begin
      valid_q <= valid_d;
      rw_q    <= rw_d;
      wreg_q  <= wreg_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_out    = valid_q;
  assign regwrite_out = rw_q;
  assign wreg_out     = wreg_q;
  assign pre_m2result = res_q;
  assign pre_zero     = zero_q;
  assign pre_overflow = ovf_q;

endmodule

// File: tb/tb_mult_m2_stage.sv
// Directed bench for mult_m2_stage: vector table plus stall,
// flush and asynchronous reset sequences.
module tb_mult_m2_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, regwrite_mult_in;
  logic [4:0]  wreg_in;
  logic        is_signed_in, neg_in;
  logic [31:0] pp_ll, pp_lh, pp_hl, pp_hh;
  logic        stall, flush;
  logic        valid_out, regwrite_out;
  logic [4:0]  wreg_out;
  logic [31:0] pre_m2result;
  logic        pre_zero, pre_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_m2_stage #(.WIDTH(32), .ADDR(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .regwrite_mult_in(regwrite_mult_in),
    .wreg_in(wreg_in), .is_signed_in(is_signed_in), .neg_in(neg_in),
    .pp_ll(pp_ll), .pp_lh(pp_lh), .pp_hl(pp_hl), .pp_hh(pp_hh),
    .stall(stall), .flush(flush),
    .valid_out(valid_out), .regwrite_out(regwrite_out),
    .wreg_out(wreg_out), .pre_m2result(pre_m2result),
    .pre_zero(pre_zero), .pre_overflow(pre_overflow)
  );

  typedef struct {
    logic        v;
    logic        rw;
    logic [4:0]  wr;
    logic        sg;
    logic        ng;
    logic [31:0] ll;
    logic [31:0] lh;
    logic [31:0] hl;
    logic [31:0] hh;
    logic [31:0] e_res;
    logic        e_z;
    logic        e_o;
    logic        e_v;
    logic        e_rw;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    valid_in         = t.v;
    regwrite_mult_in = t.rw;
    wreg_in          = t.wr;
    is_signed_in     = t.sg;
    neg_in           = t.ng;
    pp_ll            = t.ll;
    pp_lh            = t.lh;
    pp_hl            = t.hl;
    pp_hh            = t.hh;
  endtask

  task automatic check_all(input string tag, input vec_t t);
    check({tag, ".valid"},    {31'b0, valid_out},    {31'b0, t.e_v});
    check({tag, ".regwrite"}, {31'b0, regwrite_out}, {31'b0, t.e_rw});
    check({tag, ".wreg"},     {27'b0, wreg_out},     {27'b0, t.wr});
    check({tag, ".result"},   pre_m2result,          t.e_res);
    check({tag, ".zero"},     {31'b0, pre_zero},     {31'b0, t.e_z});
    check({tag, ".ovf"},      {31'b0, pre_overflow}, {31'b0, t.e_o});
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"},    {31'b0, valid_out},    32'd0);
    check({tag, ".regwrite"}, {31'b0, regwrite_out}, 32'd0);
    check({tag, ".wreg"},     {27'b0, wreg_out},     32'd0);
    check({tag, ".result"},   pre_m2result,          32'd0);
    check({tag, ".zero"},     {31'b0, pre_zero},     32'd0);
    check({tag, ".ovf"},      {31'b0, pre_overflow}, 32'd0);
  endtask

  vec_t opa, opb;

  initial begin
    //          v  rw wr  sg ng ll            lh            hl            hh            res           z  o  v  rw
    vecs[0]  = '{1, 1, 5'd1,  1, 1, 32'd21,       32'd0,        32'd0,        32'd0,        32'hFFFFFFEB, 0, 0, 1, 1};
    vecs[1]  = '{1, 1, 5'd2,  1, 0, 32'd0,        32'd0,        32'd0,        32'd1,        32'h00000000, 1, 1, 1, 1};
    vecs[2]  = '{1, 1, 5'd3,  0, 0, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'h00000001, 0, 1, 1, 1};
    vecs[3]  = '{1, 1, 5'd4,  1, 1, 32'd0,        32'd0,        32'h8000,     32'd0,        32'h80000000, 0, 0, 1, 1};
    vecs[4]  = '{1, 1, 5'd5,  1, 0, 32'd0,        32'd0,        32'h8000,     32'd0,        32'h80000000, 0, 1, 1, 1};
    vecs[5]  = '{1, 1, 5'd6,  0, 1, 32'd5,        32'd0,        32'd0,        32'd0,        32'h00000005, 0, 0, 1, 1};
    vecs[6]  = '{1, 1, 5'd7,  0, 0, 32'd0,        32'hFFFFFFFF, 32'd1,        32'd0,        32'h00000000, 1, 1, 1, 1};
    vecs[7]  = '{1, 1, 5'd8,  1, 1, 32'd0,        32'd0,        32'd0,        32'd0,        32'h00000000, 1, 0, 1, 1};
    vecs[8]  = '{0, 1, 5'd9,  0, 0, 32'd3,        32'd0,        32'd0,        32'd0,        32'h00000003, 0, 0, 0, 0};
    vecs[9]  = '{1, 0, 5'd10, 0, 0, 32'd9,        32'd0,        32'd0,        32'd0,        32'h00000009, 0, 0, 1, 0};
    vecs[10] = '{1, 1, 5'd11, 1, 0, 32'h7FFFFFFF, 32'd0,        32'd0,        32'd0,        32'h7FFFFFFF, 0, 0, 1, 1};
    vecs[11] = '{1, 1, 5'd12, 1, 1, 32'h80000001, 32'd0,        32'd0,        32'd0,        32'h7FFFFFFF, 0, 1, 1, 1};

    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(vecs[0]);
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Stall holds op A for three edges while B is presented with flush.
    opa = vecs[0];
    opa.wr = 5'd17;
    opb = vecs[1];
    opb.wr = 5'd22;
    drive(opa);
    @(posedge clk);
    #1;
    check_all("stallA.load", opa);
    drive(opb);
    stall = 1'b1;
    flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("stall%0d", k), opa);
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
    check("flush.valid",    {31'b0, valid_out},    32'd0);
    check("flush.regwrite", {31'b0, regwrite_out}, 32'd0);
    check("flush.zero",     {31'b0, pre_zero},     32'd0);
    check("flush.ovf",      {31'b0, pre_overflow}, 32'd0);
    flush = 1'b0;

    // Asynchronous reset mid-cycle with a live op loaded.
    drive(vecs[2]);
    @(posedge clk);
    #1;
    check_all("prerst", vecs[2]);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    drive(vecs[3]);
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst", vecs[3]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
